// File: rtl/ps2_host_tx_if.sv
// Command-side bundle of the PS/2 host transmitter.
// The byte moves when tx_valid && tx_ready are both high on a clock edge; tx_data must be stable while tx_valid is high.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [2:0] state_dbg;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, done, err, err_code, state_dbg
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, done, err, err_code, state_dbg
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, then shifts one odd-parity byte out on device clock falls.
// Optional PS2_TX_RETRY_EN: on NACK or timeout the same byte is resent, up to two retries.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 4
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire          PS2_CLK,
  inout  wire          PS2_DATA,
  ps2_host_tx_if.slave bus
);

  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int FW = $clog2(FILTER_LEN);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_DATA = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INHIBIT  = 3'd1,
    S_REQ      = 3'd2,
    S_SHIFT    = 3'd3,
    S_ACK      = 3'd4,
    S_WAIT_REL = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  state_t        state;
  logic          clk_drive;
  logic          dat_drive;
  logic          tx_ready_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [1:0]    err_code_q;
  logic [8:0]    frame;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  logic          to_active;
  logic          timeout_hit;
  logic          nack_hit;
  logic          fail;
  logic [1:0]    fail_code;
  logic          can_retry;

  // Open-drain: a line is only ever pulled low or left to the pull-up.
  assign PS2_CLK  = clk_drive ? 1'b0 : 1'bz;
  assign PS2_DATA = dat_drive ? 1'b0 : 1'bz;

  assign bus.tx_ready  = tx_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DATA;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      // A new clock level is taken only after FILTER_LEN differing samples in a row.
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FLT_LAST) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    to_active   = (state == S_REQ) || (state == S_SHIFT) ||
                  (state == S_ACK) || (state == S_WAIT_REL);
    timeout_hit = to_active && (to_cnt == TO_LAST);
    nack_hit    = (state == S_ACK) && fall && dat_s2;
    fail        = timeout_hit || nack_hit;
    fail_code   = timeout_hit ? 2'd2 : 2'd1;
  end

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt;
  assign can_retry = (retry_cnt != 2'd2);
`else
  assign can_retry = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      clk_drive  <= 1'b0;
      dat_drive  <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      frame      <= '0;
      bit_cnt    <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt  <= 2'd0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (fail) begin
        clk_drive  <= 1'b0;
        dat_drive  <= 1'b0;
        err_code_q <= fail_code;
        if (can_retry) begin
          state     <= S_INHIBIT;
          clk_drive <= 1'b1;
          inh_cnt   <= '0;
`ifdef PS2_TX_RETRY_EN
          retry_cnt <= retry_cnt + 2'd1;
`endif
        end else begin
          state <= S_ERR;
          err_q <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.tx_valid && tx_ready_q) begin
              frame      <= {~^bus.tx_data, bus.tx_data};
              err_code_q <= 2'd0;
              clk_drive  <= 1'b1;
              inh_cnt    <= '0;
              tx_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              state      <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retry_cnt  <= 2'd0;
`endif
            end
          end
          S_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              clk_drive <= 1'b0;
              to_cnt    <= '0;
              state     <= S_REQ;
            end else begin
              // Data goes low one cycle before the clock is released.
              if (inh_cnt == INH_DATA) dat_drive <= 1'b1;
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          S_REQ: begin
            bit_cnt <= '0;
            to_cnt  <= to_cnt + 1'b1;
            state   <= S_SHIFT;
          end
          S_SHIFT: begin
            to_cnt <= to_cnt + 1'b1;
            if (fall) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) begin
                dat_drive <= 1'b0;
                state     <= S_ACK;
              end else begin
                dat_drive <= ~frame[bit_cnt];
              end
            end
          end
          S_ACK: begin
            to_cnt <= to_cnt + 1'b1;
            if (fall) begin
              bit_cnt <= bit_cnt + 4'd1;
              state   <= S_WAIT_REL;
            end
          end
          S_WAIT_REL: begin
            to_cnt <= to_cnt + 1'b1;
            if (clk_filt && dat_s2) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
          S_DONE, S_ERR: begin
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and a scoreboard checks every bit.
module tb_ps2_host_tx;
  localparam int INH  = 200;
  localparam int TO   = 3000;
  localparam int FLT  = 4;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        ack;
    logic [10:0] exp_frame;
    logic        exp_done;
    logic [1:0]  exp_code;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  wire  ps2_clk;
  wire  ps2_data;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  assign ps2_clk  = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_data = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_data);

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FLT)) dut (
    .clk(clk), .rst(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data), .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_seen = 0;
  int err_seen  = 0;
  logic [1:0] last_code = 2'd0;
  logic [10:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_seen++;
    if (bus.err === 1'b1) begin
      err_seen++;
      last_code = bus.err_code;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // driver tasks
  task automatic accept(input logic [7:0] d);
    @(negedge clk);
    check("tx_ready_idle", 32'(bus.tx_ready), 1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("clk_low_after_accept", 32'(ps2_clk), 0);
    check("busy_after_accept", 32'(bus.busy), 1);
  endtask

  task automatic wait_low();
    for (int i = 0; i < 300; i++) begin
      if (ps2_clk === 1'b0) break;
      @(negedge clk);
    end
    check("retry_inhibit", 32'(ps2_clk), 0);
  endtask

  task automatic wait_release(output int inh_len, output int both_low);
    inh_len  = 0;
    both_low = 0;
    for (int i = 0; i < INH + 50; i++) begin
      if (ps2_clk !== 1'b0) break;
      inh_len++;
      if (ps2_data === 1'b0) both_low++;
      @(negedge clk);
    end
  endtask

  task automatic dev_frame(input logic ack, input logic poke, input logic [7:0] poke_data,
                           output logic [10:0] bits);
    repeat (12) @(negedge clk);
    bits[0] = ps2_data;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      if (poke && k == 3) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = poke_data;
      end
      repeat (HALF) @(negedge clk);
      bits[k] = ps2_data;
      if (poke && k == 10) begin
        check("tx_ready_busy", 32'(bus.tx_ready), 0);
        bus.tx_valid = 1'b0;
      end
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (ack) dev_dat_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] d, input logic ack, input logic [10:0] exp_frame,
                         input logic exp_done, input logic [1:0] exp_code, input logic poke);
    int d0, e0, len, bl, n_att;
    logic [10:0] bits;
    d0 = done_seen;
    e0 = err_seen;
    accept(d);
    n_att = ack ? 1 : ATTEMPTS;
    for (int a = 0; a < n_att; a++) begin
      if (a > 0) wait_low();
      wait_release(len, bl);
      if (a == 0) begin
        check("inhibit_len", 32'(len), INH);
        check("data_low_last_inhibit", 32'(bl), 1);
      end
      exp_q.push_back(exp_frame);
      dev_frame(ack, poke, ~d, bits);
      check("frame_bits", 32'(bits), 32'(exp_q.pop_front()));
    end
    for (int i = 0; i < 100; i++) begin
      if (done_seen != d0 || err_seen != e0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_seen - d0), 32'(exp_done));
    check("err_pulses", 32'(err_seen - e0), 32'(!exp_done));
    check("err_code", 32'(bus.err_code), 32'(exp_code));
    check("tx_ready_after", 32'(bus.tx_ready), 1);
    check("lines_released", 32'({ps2_clk, ps2_data}), 3);
  endtask

  vec_t vecs[6];

  initial begin
    int len, bl, cnt, d0, e0;
    logic [7:0] d;
    logic ack;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    vecs[0] = '{8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1, 2'd0};
    vecs[1] = '{8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b1, 2'd0};
    vecs[2] = '{8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1, 2'd0};
    vecs[3] = '{8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1, 2'd0};
    vecs[4] = '{8'h7F, 1'b1, {1'b1, 1'b0, 8'h7F, 1'b0}, 1'b1, 2'd0};
    vecs[5] = '{8'hA5, 1'b0, {1'b1, 1'b1, 8'hA5, 1'b0}, 1'b0, 2'd1};

    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(bus.tx_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done_err", 32'({bus.done, bus.err}), 0);
    check("rst_err_code", 32'(bus.err_code), 0);
    check("rst_state", 32'(bus.state_dbg), 0);
    check("rst_lines", 32'({ps2_clk, ps2_data}), 3);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i])
      run_txn(vecs[i].data, vecs[i].ack, vecs[i].exp_frame, vecs[i].exp_done, vecs[i].exp_code, 1'b0);

    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 3) != 0);
      run_txn(d, ack, model_frame(d), ack, ack ? 2'd0 : 2'd1, 1'b0);
    end

    // new byte offered mid-frame must not disturb the wire
    run_txn(8'h3C, 1'b1, model_frame(8'h3C), 1'b1, 2'd0, 1'b1);

    // device never clocks: timeout measured from clock release
    d0 = done_seen;
    e0 = err_seen;
    accept(8'h5A);
    for (int a = 0; a < ATTEMPTS; a++) begin
      if (a > 0) wait_low();
      wait_release(len, bl);
      cnt = 0;
      for (int i = 0; i < TO + 50; i++) begin
        if (bus.err === 1'b1 || ps2_clk === 1'b0) break;
        @(negedge clk);
        cnt++;
      end
      check("timeout_cycles", 32'(cnt), TO);
    end
    check("timeout_err", 32'(bus.err), 1);
    check("timeout_code", 32'(bus.err_code), 2);
    check("timeout_lines", 32'({ps2_clk, ps2_data}), 3);
    repeat (3) @(negedge clk);
    check("timeout_pulses", 32'({err_seen - e0, done_seen - d0}), 32'({32'd1, 32'd0}));

    // reset after fall 5 while the host drives data bit 4 low
    accept(8'h0F);
    wait_release(len, bl);
    repeat (12) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    repeat (12) @(negedge clk);
    check("bit4_driven_low", 32'(ps2_data), 0);
    d0 = done_seen;
    e0 = err_seen;
    #1 rst = 1'b0;
    #1 check("rst_async_data_released", 32'(ps2_data), 1);
    check("rst_async_busy", 32'(bus.busy), 0);
    dev_clk_low = 1'b0;
    #1 check("rst_async_clk_released", 32'(ps2_clk), 1);
    repeat (5) @(negedge clk);
    check("rst_no_pulses", 32'((done_seen - d0) + (err_seen - e0)), 0);
    check("rst_err_code_clear", 32'(bus.err_code), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    run_txn(8'h0F, 1'b1, model_frame(8'h0F), 1'b1, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, for game-state LED feedback.
- Sits beside the keyboard receive path on the same PS2_CLK/PS2_DATA lines and drives them open-drain.
- Asserts busy so the receive path can ignore line activity during a host transfer.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles PS2_CLK is held low before the start bit (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum clk cycles from clock release to ack completion (20 ms at 100 MHz).
- FILTER_LEN, 4: consecutive equal synchronized samples required to accept a new PS2_CLK level.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-low reset.
- PS2_CLK  inout  1  PS/2 clock, open-drain: driven 0 or released to z.
- PS2_DATA  inout  1  PS/2 data, open-drain: driven 0 or released to z.
- tx_valid  input  1  request to send tx_data.
- tx_data  input  8  command byte.
- tx_ready  output  1  high only in IDLE; the byte is accepted when tx_valid && tx_ready.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the device acks and both lines have returned high.
- err  output  1  one-cycle pulse on failure.
- err_code  output  2  valid with err and held until the next accept: 1 = NACK, 2 = timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; both lines released (z).
  - tx_ready=1, busy=0, done=0, err=0, err_code=0.
  - Counters cleared; shift register cleared.
  - Reset mid-frame releases both lines immediately, with no completion pulse.
- Input conditioning:
  - PS2_CLK and PS2_DATA pass through a 2-FF synchronizer.
  - The clock level is filtered by FILTER_LEN.
  - fall = one-cycle pulse when the filtered clock goes 1 to 0.
- On accept:
  - Latch frame {parity, tx_data}, where parity = ~^tx_data (odd parity).
  - Clear err_code and enter INHIBIT.
- States:
  - IDLE: lines released; wait for accept.
  - INHIBIT: drive PS2_CLK=0 for INHIBIT_CYCLES cycles. On the last cycle also drive PS2_DATA=0, then go to REQ.
  - REQ: release PS2_CLK, keep PS2_DATA=0 (start bit), bit_cnt=0, start the timeout counter, go to SHIFT.
  - SHIFT, on each fall, bit_cnt increments:
    - fall 1..8: drive PS2_DATA = tx_data[bit_cnt-1], LSB first. 0 is driven low, 1 is released.
    - fall 9: drive parity the same way.
    - fall 10: release PS2_DATA (stop bit); go to ACK.
  - ACK: on fall 11, sample synchronized PS2_DATA.
    - 0: go to WAIT_REL.
    - 1: go to ERR with code 1.
  - WAIT_REL: wait until filtered clock and synchronized data are both 1, then go to DONE.
  - DONE: pulse done for one cycle, go to IDLE.
  - ERR: release both lines, pulse err for one cycle, go to IDLE.
- Timeout:
  - Counter runs from REQ until leaving WAIT_REL.
  - Reaching TIMEOUT_CYCLES in REQ, SHIFT, ACK or WAIT_REL: go to ERR with code 2.
- tx_valid while busy is ignored; no queueing.
- The PS/2 clock is never driven outside INHIBIT.
- Latency: PS2_CLK goes low on the cycle after accept; done follows device completion by about 4–6 cycles (sync + filter).
- Counter widths are sized with $clog2 of the parameters; no overflow is possible.

Optional Feature:
- PS2_TX_RETRY_EN defined:
  - On NACK or timeout, re-enter INHIBIT with the same byte, up to 2 retries.
  - err pulses only after the 3rd failure, with err_code of the final attempt.
  - busy stays high throughout; retry count clears on accept and reset.
- Undefined: the first failure goes straight to ERR.

Test Plan:
- Send 0xED with a device model acking at fall 11:
  - PS2_CLK low for 12000 cycles, then data bits 1,0,1,1,0,1,1,1, parity 1, stop released.
  - done pulses once; err stays 0.
- Send 0x01: data 1,0,0,0,0,0,0,0, parity 0. Send 0x00: parity 1. Both end with done.
- Device leaves data high at fall 11: err=1 for one cycle, err_code=1, tx_ready returns to 1.
  - With PS2_TX_RETRY_EN: 3 full frames are seen before err.
- Device never clocks after REQ: err pulses with err_code=2 exactly TIMEOUT_CYCLES after REQ; both lines released.
- tx_valid held high with a new byte during SHIFT: the byte is ignored and the frame on the wire is unchanged.
- rst asserted after fall 5: both lines go z asynchronously; no done or err; the next accept sends a complete, correct frame.
